// File: rtl/mux_sched_pkg.sv
// Shared definitions for the mux select scheduler.
//   state_t        : scheduler FSM state (IDLE while no grant, HOLD while a channel owns the mux)
//   CH_A..CH_D     : 2-bit mux select codes of the four channels
//   DWELL_DEFAULT  : default number of cycles a granted channel holds the mux
package mux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  localparam int unsigned DWELL_DEFAULT = 4;

endpackage

// File: rtl/mux_sel_scheduler_rr_pick4.sv
// Combinational 4-way rotating priority picker.
//   req[3:0] : request per channel, bit index = channel code
//   ptr[1:0] : channel with highest priority; priority falls off as ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   any      : at least one request is high
//   sel[1:0] : first requesting channel in rotated order (equals ptr when any=0)
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] sel
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    any   = |req;
    sel   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      // 2-bit addition wraps D+1 back to A
      idx = ptr + i[1:0];
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin select generator driving the S1/S0 pair of a 2-bit 4:1 data mux.
//   clk, rst_n        : clock (rising edge) and synchronous active-low reset
//   ReqA..ReqD        : channel requests (mux codes 00, 01, 10, 11)
//   S1, S0            : registered mux select
//   Valid             : a grant is active, mux output carries granted data
//   AckA..AckD        : one-cycle pulse when the channel's dwell period completed
// A granted channel holds the mux for DWELL cycles while its request stays high.
// Dropping the request aborts the grant without an acknowledge.
module mux_sel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT,
  parameter int unsigned CW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ReqA,
  input  logic ReqB,
  input  logic ReqC,
  input  logic ReqD,
  output logic S1,
  output logic S0,
  output logic Valid,
  output logic AckA,
  output logic AckB,
  output logic AckC,
  output logic AckD
);

  state_t          state_q, state_nxt;
  logic [1:0]      sel_q, sel_nxt;
  logic [1:0]      ptr_q, ptr_nxt;
  logic [3:0]      ack_q, ack_nxt;
  logic            valid_q, valid_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;

  logic [3:0]      req;
  logic [1:0]      pick_ptr, pick_sel;
  logic            pick_any;
  logic            granted;
  logic            expire;

  assign req     = {ReqD, ReqC, ReqB, ReqA};
  assign granted = req[sel_q];
  assign expire  = (cnt_q == '0);

  // While holding, the only arbitration that matters is the back-to-back one
  // at expiry, which starts just after the channel being served.
  assign pick_ptr = (state_q == HOLD) ? sel_q + 2'd1 : ptr_q;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .sel (pick_sel)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= CH_A;
      ptr_q   <= CH_A;
      ack_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      ptr_q   <= ptr_nxt;
      ack_q   <= ack_nxt;
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next-state logic; abort (request dropped) outranks expiry
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: if (pick_any) state_nxt = HOLD;
      HOLD: begin
        if (!granted)               state_nxt = IDLE;
        else if (expire && !pick_any) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and dwell counter
  always_comb begin
    sel_nxt   = sel_q;
    ptr_nxt   = ptr_q;
    ack_nxt   = '0;
    valid_nxt = 1'b0;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_nxt   = pick_sel;
          valid_nxt = 1'b1;
          cnt_nxt   = CW'(DWELL - 1);
        end
      end
      HOLD: begin
        if (!granted) begin
          ptr_nxt = sel_q + 2'd1;
        end else if (expire) begin
          ack_nxt[sel_q] = 1'b1;
          ptr_nxt        = sel_q + 2'd1;
          if (pick_any) begin
            sel_nxt   = pick_sel;
            valid_nxt = 1'b1;
            cnt_nxt   = CW'(DWELL - 1);
          end
        end else begin
          cnt_nxt   = cnt_q - CW'(1);
          valid_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign Valid = valid_q;
  assign AckA  = ack_q[0];
  assign AckB  = ack_q[1];
  assign AckC  = ack_q[2];
  assign AckD  = ack_q[3];

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler: three instances (DWELL 4, 2, 1) share
// the request/reset stimulus; a grant-level model is checked every cycle and
// hand-computed expectations are checked at selected points.
module tb_mux_sel_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;   // {D, C, B, A}

  logic [2:0]      s1_w, s0_w, v_w;
  logic [2:0][3:0] ack_w;

  int vectors;
  int miscompares;

  localparam int NI = 3;
  int dw [NI] = '{4, 2, 1};

  // model state
  int         own  [NI];   // owning channel or -1
  int         el   [NI];   // cycles the current grant has been visible
  int         mptr [NI];
  logic [1:0] esel [NI];
  logic       ev   [NI];
  logic [3:0] eack [NI];

  mux_sel_scheduler #(.DWELL(4), .CW(8)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .ReqA(req[0]), .ReqB(req[1]), .ReqC(req[2]), .ReqD(req[3]),
    .S1(s1_w[0]), .S0(s0_w[0]), .Valid(v_w[0]),
    .AckA(ack_w[0][0]), .AckB(ack_w[0][1]), .AckC(ack_w[0][2]), .AckD(ack_w[0][3])
  );

  mux_sel_scheduler #(.DWELL(2), .CW(8)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .ReqA(req[0]), .ReqB(req[1]), .ReqC(req[2]), .ReqD(req[3]),
    .S1(s1_w[1]), .S0(s0_w[1]), .Valid(v_w[1]),
    .AckA(ack_w[1][0]), .AckB(ack_w[1][1]), .AckC(ack_w[1][2]), .AckD(ack_w[1][3])
  );

  mux_sel_scheduler #(.DWELL(1), .CW(8)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .ReqA(req[0]), .ReqB(req[1]), .ReqC(req[2]), .ReqD(req[3]),
    .S1(s1_w[2]), .S0(s0_w[2]), .Valid(v_w[2]),
    .AckA(ack_w[2][0]), .AckB(ack_w[2][1]), .AckC(ack_w[2][2]), .AckD(ack_w[2][3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string name, input int inst,
                     input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst=%0d (dwell %0d) t=%0t actual=%0h required=%0h",
               name, inst, dw[inst], $time, act, exp);
    end
  endtask

  // grant-level model update and per-cycle comparison
  initial begin
    for (int i = 0; i < NI; i++) begin
      own[i] = -1; el[i] = 0; mptr[i] = 0;
      esel[i] = 2'd0; ev[i] = 1'b0; eack[i] = 4'd0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          own[i] = -1; mptr[i] = 0; esel[i] = 2'd0; eack[i] = 4'd0;
        end else begin
          eack[i] = 4'd0;
          if (own[i] >= 0) begin
            if (!req[own[i]]) begin
              mptr[i] = (own[i] + 1) % 4;
              own[i]  = -1;
            end else if (el[i] == dw[i]) begin
              eack[i] = 4'(1 << own[i]);
              mptr[i] = (own[i] + 1) % 4;
              own[i]  = pick(mptr[i], req);
              el[i]   = 1;
            end else begin
              el[i]++;
            end
          end else begin
            own[i] = pick(mptr[i], req);
            el[i]  = 1;
          end
          if (own[i] >= 0) esel[i] = 2'(own[i]);
        end
        ev[i] = (own[i] >= 0);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        chk("sel",   i, {2'b00, s1_w[i], s0_w[i]}, {2'b00, esel[i]});
        chk("valid", i, {3'b000, v_w[i]}, {3'b000, ev[i]});
        chk("ack",   i, ack_w[i], eack[i]);
      end
    end
  end

  // hand-computed expectations, checked against both DUT and model
  task automatic lit(input int i, input logic [1:0] s, input logic v, input logic [3:0] a);
    chk("lit_sel",     i, {2'b00, s1_w[i], s0_w[i]}, {2'b00, s});
    chk("lit_valid",   i, {3'b000, v_w[i]}, {3'b000, v});
    chk("lit_ack",     i, ack_w[i], a);
    chk("model_sel",   i, {2'b00, esel[i]}, {2'b00, s});
    chk("model_valid", i, {3'b000, ev[i]}, {3'b000, v});
    chk("model_ack",   i, eack[i], a);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = r;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_with(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b1;
    req   = r;
  endtask

  logic [1:0] d2_sel [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
  logic [3:0] d2_ack [9] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req   = 4'b1111;

    // reset with every request high
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) lit(i, 2'd0, 1'b0, 4'h0);
    release_with(4'b1111);
    step();
    for (int i = 0; i < NI; i++) lit(i, 2'd0, 1'b1, 4'h0);

    // single requester C
    do_reset(4'b0000);
    release_with(4'b0100);
    for (int k = 1; k <= 5; k++) begin
      step();
      lit(0, 2'd2, 1'b1, (k == 5) ? 4'h4 : 4'h0);
      lit(2, 2'd2, 1'b1, (k == 1) ? 4'h0 : 4'h4);
    end

    // all four requesting
    do_reset(4'b0000);
    release_with(4'b1111);
    for (int k = 1; k <= 9; k++) begin
      step();
      lit(1, d2_sel[k-1], 1'b1, d2_ack[k-1]);
      lit(2, 2'((k - 1) % 4), 1'b1, (k == 1) ? 4'h0 : 4'(1 << ((k - 2) % 4)));
    end

    // abort of B in its second hold cycle; next grant starts at C
    do_reset(4'b0000);
    release_with(4'b0010);
    step();
    lit(0, 2'd1, 1'b1, 4'h0);
    step();
    lit(0, 2'd1, 1'b1, 4'h0);
    @(negedge clk);
    req = 4'b0101;
    step();
    lit(0, 2'd1, 1'b0, 4'h0);
    step();
    lit(0, 2'd2, 1'b1, 4'h0);

    // pointer moved to D, then A and D alternate with wrap-around
    do_reset(4'b0000);
    release_with(4'b0100);
    step();
    @(negedge clk);
    req = 4'b0000;
    step();
    lit(0, 2'd2, 1'b0, 4'h0);
    @(negedge clk);
    req = 4'b1001;
    step();
    lit(0, 2'd3, 1'b1, 4'h0);
    repeat (3) step();
    step();
    lit(0, 2'd0, 1'b1, 4'h8);
    repeat (3) step();
    step();
    lit(0, 2'd3, 1'b1, 4'h1);

    // reset in the middle of a grant of B
    do_reset(4'b0000);
    release_with(4'b0010);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    lit(0, 2'd0, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    lit(0, 2'd0, 1'b1, 4'h0);
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
